// File: rtl/sap1_controller.sv
`default_nettype none
// ============================================================================
// Module      : sap1_controller
// Description : Controller/sequencer for the SAP-1 datapath. A six-state
//               one-hot ring counter (T1..T6) advances on the falling edge of
//               clk. The control word is decoded combinationally from the
//               ring counter and the IR opcode, so it settles half a cycle
//               before the rising edge where the datapath registers load.
//               HLT freezes the ring counter in T4 until reset.
// Ports       : clk      - system clock (datapath loads on rising edge)
//               reset    - asynchronous active-low reset
//               opcode   - IR upper nibble, stable from T3 rise to end of T6
//               pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out,
//               a_load, a_out, b_load, alu_sub, alu_out, out_load
//                        - datapath control word
//               halt     - machine halted
//               t_state  - one-hot ring counter, bit0 = T1
// Revision    : 1.0 - initial release
// ============================================================================
module sap1_controller #(
  parameter int                      OPCODE_WIDTH = 4,
  parameter logic [OPCODE_WIDTH-1:0] OP_LDA       = 4'b0000,
  parameter logic [OPCODE_WIDTH-1:0] OP_ADD       = 4'b0001,
  parameter logic [OPCODE_WIDTH-1:0] OP_SUB       = 4'b0010,
  parameter logic [OPCODE_WIDTH-1:0] OP_OUT       = 4'b1110,
  parameter logic [OPCODE_WIDTH-1:0] OP_HLT       = 4'b1111
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output logic                    pc_inc,
  output logic                    pc_out,
  output logic                    mar_load,
  output logic                    ram_out,
  output logic                    ir_load,
  output logic                    ir_out,
  output logic                    a_load,
  output logic                    a_out,
  output logic                    b_load,
  output logic                    alu_sub,
  output logic                    alu_out,
  output logic                    out_load,
  output logic                    halt,
  output logic [5:0]              t_state
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  t_state_e t_state_q;
  t_state_e t_state_d;

  // Next ring position. HLT in T4 holds the counter; any illegal encoding
  // falls into the default arm and restarts at fetch.
  always_comb begin
    t_state_d = T1;
    case (t_state_q)
      T1:      t_state_d = T2;
      T2:      t_state_d = T3;
      T3:      t_state_d = T4;
      T4:      t_state_d = (opcode == OP_HLT) ? T4 : T5;
      T5:      t_state_d = T6;
      T6:      t_state_d = T1;
      default: t_state_d = T1;
    endcase
  end

  // Falling-edge update gives the decode half a cycle to settle before the
  // datapath samples the control word on the rising edge.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      t_state_q <= T1;
    end else begin
      t_state_q <= t_state_d;
    end
  end

  // While reset is low the ring counter is already T1, but the output is
  // forced as well so it is valid before the first clock edge ever arrives.
  assign t_state = reset ? t_state_q : T1;

  // Control word decode; reset low overrides everything to 0.
  always_comb begin
    pc_inc   = 1'b0;
    pc_out   = 1'b0;
    mar_load = 1'b0;
    ram_out  = 1'b0;
    ir_load  = 1'b0;
    ir_out   = 1'b0;
    a_load   = 1'b0;
    a_out    = 1'b0;
    b_load   = 1'b0;
    alu_sub  = 1'b0;
    alu_out  = 1'b0;
    out_load = 1'b0;
    halt     = 1'b0;
    if (reset) begin
      case (t_state_q)
        T1: begin
          pc_out   = 1'b1;
          mar_load = 1'b1;
        end
        T2: begin
          pc_inc = 1'b1;
        end
        T3: begin
          ram_out = 1'b1;
          ir_load = 1'b1;
        end
        T4: begin
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
            ir_out   = 1'b1;
            mar_load = 1'b1;
          end else if (opcode == OP_OUT) begin
            a_out    = 1'b1;
            out_load = 1'b1;
          end else if (opcode == OP_HLT) begin
            halt = 1'b1;
          end
        end
        T5: begin
          if (opcode == OP_LDA) begin
            ram_out = 1'b1;
            a_load  = 1'b1;
          end else if (opcode == OP_ADD || opcode == OP_SUB) begin
            ram_out = 1'b1;
            b_load  = 1'b1;
          end
        end
        T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_out = 1'b1;
            a_load  = 1'b1;
            alu_sub = (opcode == OP_SUB);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
